// File: rtl/comb_tap_sequencer.sv
// Purpose : sequences a shared single-port delay-line BRAM; writes each accepted sample
//           at a circular pointer, then reads one tap per configured delay and streams them.
// Latency : tap k appears 3+k cycles after the accept cycle; frame_done 3+NTAPS cycles after it.
// Backpressure: none; a sample strobe arriving while busy is dropped and flagged in sticky overrun.
// Ports   : clk/reset (sync, active-high); ready/x sample input; cfg_we/cfg_idx/cfg_delay staging
//           table write; mem_addr/mem_we/mem_din/mem_dout BRAM port (1-cycle read latency);
//           tap_valid/tap_idx/tap_data tap stream; frame_done, busy, overrun status.
module comb_tap_sequencer #(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 12000,
    parameter int NTAPS  = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    input  logic [DATA_W-1:0] x,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_idx,
    input  logic [ADDR_W-1:0] cfg_delay,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              tap_valid,
    output logic [3:0]        tap_idx,
    output logic [DATA_W-1:0] tap_data,
    output logic              frame_done,
    output logic              busy,
    output logic              overrun
);

    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_M1 = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] WPTR_MAX = ADDR_W'(DEPTH - 1);
    localparam logic [3:0]        LAST_K   = 4'(NTAPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;
    logic [3:0] k, k_nxt;

    logic [ADDR_W-1:0] wptr;
    logic [DATA_W-1:0] x_lat;
    logic [ADDR_W-1:0] staging [NTAPS];
    logic [ADDR_W-1:0] active  [NTAPS];

    logic [ADDR_W-1:0] addr_q;
    logic              rd_zero;     // delay of the read currently on mem_addr is 0
    logic              tap_vld_q;
    logic [3:0]        tap_idx_q;
    logic              tap_zero_q;  // tap being output bypasses the BRAM
    logic [DATA_W-1:0] tap_hold;
    logic              overrun_q;

    logic              accept;
    logic [3:0]        rd_idx;
    logic [ADDR_W-1:0] d_sel;
    logic [ADDR_W-1:0] raddr;

    // Circular read address for delay d behind write pointer w; d clamped to DEPTH-1.
    function automatic logic [ADDR_W-1:0] calc_raddr(input logic [ADDR_W-1:0] w,
                                                     input logic [ADDR_W-1:0] d);
        logic [ADDR_W:0] wx, dc, r;
        wx = {1'b0, w};
        dc = ({1'b0, d} >= DEPTH_X) ? DEPTH_M1 : {1'b0, d};
        r  = (wx >= dc) ? (wx - dc) : (wx + DEPTH_X - dc);
        return r[ADDR_W-1:0];
    endfunction

    assign accept = (state == S_IDLE) && ready;

    // The address register is loaded one cycle ahead of use: the WRITE cycle
    // loads tap 0, READ k loads tap k+1.
    assign rd_idx = (state == S_WRITE) ? 4'd0 : (k + 4'd1);

    always_comb begin
        d_sel = '0;
        for (int i = 0; i < NTAPS; i++) begin
            if (rd_idx == 4'(i)) begin
                d_sel = active[i];
            end
        end
    end

    assign raddr = calc_raddr(wptr, d_sel);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            k     <= 4'd0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        case (state)
            S_IDLE:  if (ready) state_nxt = S_WRITE;
            S_WRITE: begin
                state_nxt = S_READ;
                k_nxt     = 4'd0;
            end
            S_READ: begin
                if (k == LAST_K) state_nxt = S_DRAIN;
                else             k_nxt     = k + 4'd1;
            end
            S_DRAIN: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr       <= '0;
            x_lat      <= '0;
            addr_q     <= '0;
            rd_zero    <= 1'b0;
            tap_vld_q  <= 1'b0;
            tap_idx_q  <= 4'd0;
            tap_zero_q <= 1'b0;
            tap_hold   <= '0;
            overrun_q  <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                staging[i] <= '0;
                active[i]  <= '0;
            end
        end else begin
            // Staging writes with an index beyond NTAPS-1 match no entry.
            for (int i = 0; i < NTAPS; i++) begin
                if (cfg_we && (cfg_idx == 4'(i))) begin
                    staging[i] <= cfg_delay;
                end
            end

            if (accept) begin
                x_lat  <= x;
                addr_q <= wptr;
                // Snapshot sees the staging value before any coincident cfg write.
                for (int i = 0; i < NTAPS; i++) begin
                    active[i] <= staging[i];
                end
            end

            if ((state == S_WRITE) || ((state == S_READ) && (k != LAST_K))) begin
                addr_q  <= raddr;
                rd_zero <= (d_sel == '0);
            end

            tap_vld_q <= (state == S_READ);
            if (state == S_READ) begin
                tap_idx_q  <= k;
                tap_zero_q <= rd_zero;
            end

            if (tap_vld_q) begin
                tap_hold <= tap_data;
            end

            if (state == S_DONE) begin
                wptr <= (wptr == WPTR_MAX) ? '0 : (wptr + 1'b1);
            end

            if (ready && (state != S_IDLE)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // mem_dout is already registered by the BRAM, so it is passed straight through
    // while a tap is valid; tap_hold keeps the last value in between.
    assign tap_data   = tap_vld_q ? (tap_zero_q ? x_lat : mem_dout) : tap_hold;
    assign tap_valid  = tap_vld_q;
    assign tap_idx    = tap_idx_q;
    assign mem_addr   = addr_q;
    assign mem_we     = (state == S_WRITE);
    assign mem_din    = x_lat;
    assign frame_done = (state == S_DONE);
    assign busy       = (state != S_IDLE);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_comb_tap_sequencer.sv
// Purpose : randomized self-checking bench for comb_tap_sequencer against a sample-history model.
// Latency : checks every cycle of each frame (accept through frame_done).
// Backpressure: exercises dropped strobes (overrun) and mid-frame reset.
module tb_comb_tap_sequencer;

    localparam int AW    = 6;
    localparam int DEPTH = 16;
    localparam int NT    = 3;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          ready;
    logic [DW-1:0] x;
    logic          cfg_we;
    logic [3:0]    cfg_idx;
    logic [AW-1:0] cfg_delay;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic          tap_valid;
    logic [3:0]    tap_idx;
    logic [DW-1:0] tap_data;
    logic          frame_done;
    logic          busy;
    logic          overrun;

    comb_tap_sequencer #(
        .ADDR_W (AW),
        .DEPTH  (DEPTH),
        .NTAPS  (NT),
        .DATA_W (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ready      (ready),
        .x          (x),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_delay  (cfg_delay),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .tap_valid  (tap_valid),
        .tap_idx    (tap_idx),
        .tap_data   (tap_data),
        .frame_done (frame_done),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Single-port BRAM, registered read, 1-cycle latency.
    logic [DW-1:0] bram [1 << AW];
    always @(posedge clk) begin
        if (mem_we) bram[mem_addr] <= mem_din;
        mem_dout <= bram[mem_addr];
    end

    // Reference model: sample history per buffer slot, write slot, staging table.
    logic [DW-1:0] mm [DEPTH];
    int            w;
    int            stg [NT];
    bit            ovr;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        reset  = 1'b0;
        ready  = 1'b0;
        cfg_we = 1'b0;
        x      = 8'($urandom);
    endtask

    task automatic cfg_write(input int idx, input int dly);
        @(negedge clk);
        reset     = 1'b0;
        ready     = 1'b0;
        cfg_we    = 1'b1;
        cfg_idx   = 4'(idx);
        cfg_delay = AW'(dly);
        if (idx < NT) stg[idx] = dly;
    endtask

    // One full frame starting at cycle c=0 (strobe). Optional extra strobe at
    // dup_at and a staging write at race_at (both relative to c=0, -1 = none).
    task automatic run_frame(input logic [DW-1:0] xv, input int dup_at,
                             input int race_at, input int race_idx, input int race_dly);
        int            act [NT];
        int            ea  [NT];
        logic [DW-1:0] et  [NT];
        int            d;
        for (int k = 0; k < NT; k++) act[k] = stg[k];
        mm[w] = xv;
        for (int k = 0; k < NT; k++) begin
            d     = (act[k] >= DEPTH) ? DEPTH - 1 : act[k];
            ea[k] = (w - d + DEPTH) % DEPTH;
            et[k] = (d == 0) ? xv : mm[ea[k]];
        end
        for (int c = 0; c <= NT + 3; c++) begin
            @(negedge clk);
            reset     = 1'b0;
            ready     = (c == 0) || (c == dup_at);
            x         = (c == 0) ? xv : 8'($urandom);
            cfg_we    = (c == race_at);
            cfg_idx   = 4'(race_idx);
            cfg_delay = AW'(race_dly);
            #1;
            if (c == 0) check("busy_idle", busy, 0);
            if (c == 1) begin
                check("wr_we", mem_we, 1);
                check("wr_addr", mem_addr, w);
                check("wr_din", mem_din, xv);
                check("busy_frame", busy, 1);
            end
            if (c >= 2 && c <= NT + 1) begin
                check("rd_we", mem_we, 0);
                check("rd_addr", mem_addr, ea[c-2]);
            end
            if (c == 2) check("tap_vld_early", tap_valid, 0);
            if (c >= 3 && c <= NT + 2) begin
                check("tap_vld", tap_valid, 1);
                check("tap_idx", tap_idx, c - 3);
                check("tap_data", tap_data, et[c-3]);
                check("done_early", frame_done, 0);
            end
            if (c == NT + 3) begin
                check("frame_done", frame_done, 1);
                check("tap_vld_done", tap_valid, 0);
                check("tap_hold", tap_data, et[NT-1]);
            end
        end
        if (dup_at > 0) ovr = 1'b1;
        if (race_at >= 0 && race_idx < NT) stg[race_idx] = race_dly;
        w = (w + 1) % DEPTH;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_din"}, mem_din, 0);
        check({tag, "_tvld"}, tap_valid, 0);
        check({tag, "_tidx"}, tap_idx, 0);
        check({tag, "_tdat"}, tap_data, 0);
        check({tag, "_done"}, frame_done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ovr"}, overrun, 0);
    endtask

    task automatic model_reset();
        w   = 0;
        ovr = 1'b0;
        for (int k = 0; k < NT; k++) stg[k] = 0;
    endtask

    initial begin
        logic [DW-1:0] xv;
        for (int i = 0; i < (1 << AW); i++) bram[i] = '0;
        for (int i = 0; i < DEPTH; i++) mm[i] = '0;
        mem_dout  = '0;
        reset     = 1'b1;
        ready     = 1'b0;
        x         = '0;
        cfg_we    = 1'b0;
        cfg_idx   = '0;
        cfg_delay = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs("rst");

        // Basic streaming with delays {1,4,15}; wraps the write pointer.
        cfg_write(0, 1);
        cfg_write(1, 4);
        cfg_write(2, 15);
        for (int n = 1; n <= 20; n++) begin
            run_frame(8'(n), -1, -1, 0, 0);
            idle_cycle();
        end

        // Zero delay and clamping.
        cfg_write(0, 0);
        cfg_write(1, 16);
        cfg_write(2, 40);
        run_frame(8'hF9, -1, -1, 0, 0);

        // Staging write during a frame, and one coincident with accept.
        cfg_write(1, 4);
        run_frame(8'h11, -1, 2, 1, 2);
        run_frame(8'h22, -1, 0, 2, 7);
        run_frame(8'h33, -1, -1, 0, 0);

        // Dropped strobe mid-frame and in the DONE cycle; overrun is sticky.
        check("ovr_before", overrun, 0);
        run_frame(8'h44, 3, -1, 0, 0);
        #1 check("ovr_set", overrun, 1);
        run_frame(8'h55, NT + 3, -1, 0, 0);
        idle_cycle();
        #1 check("ovr_hold", overrun, 1);

        // Reset mid-frame at cycle 4.
        xv = 8'h66;
        @(negedge clk); ready = 1'b1; x = xv; cfg_we = 1'b0;
        mm[w] = xv;
        @(negedge clk); ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("midrst");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            check("midrst_nodone", frame_done, 0);
        end
        run_frame(8'h77, -1, -1, 0, 0);

        // Randomized traffic.
        for (int it = 0; it < 60; it++) begin
            int ncfg = $urandom_range(0, 2);
            for (int j = 0; j < ncfg; j++)
                cfg_write($urandom_range(0, 5), $urandom_range(0, 63));
            repeat ($urandom_range(0, 2)) idle_cycle();
            run_frame(8'($urandom),
                      ($urandom_range(0, 7) == 0) ? $urandom_range(1, NT + 3) : -1,
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, NT + 3) : -1,
                      $urandom_range(0, 4), $urandom_range(0, 63));
        end
        idle_cycle();
        #1 check("ovr_final", overrun, 32'(ovr));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
